st_bus_arbiter: RTL and testbench

Bus-mastership arbiter between the 68000-compatible CPU wrapper and up to NREQ DMA requesters (blitter, ACSI/floppy DMA). It runs the 68000 BR/BG/BGACK handshake toward the CPU. It picks one requester by round-robin, holds the bus for that requester until it drops its request or its tenure limit expires, then hands the bus back to the CPU. It sits between the CPU wrapper's arbitration pins and the DMA engines' request/grant pairs.

---
 rtl/st_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_st_bus_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st_bus_arbiter.sv
// Bus-mastership arbiter: runs the 68000 BR/BG/BGACK handshake on behalf of up to
// NREQ DMA engines, granting them round-robin, one tenure at a time.
module st_bus_arbiter #(
  parameter int NREQ       = 2,
  parameter int MAX_TENURE = 64,
  parameter int BG_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            phi2,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            br_n,
  input  logic            bg_n,
  output logic            bgack_n,
  input  logic            as_n,
  output logic            busy,
  output logic            timeout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_WAITAS  = 3'd2;
  localparam logic [2:0] S_OWN     = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [IW-1:0] LAST_RST       = IW'(NREQ - 1);
  localparam bit            TENURE_LIMITED = (MAX_TENURE != 0);
  localparam logic [7:0]    TENURE_LAST    = 8'(MAX_TENURE - 1);
  localparam logic [7:0]    TIMEOUT_LIM    = 8'(BG_TIMEOUT);

  logic [2:0]      state;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   last;
  logic [7:0]      wait_cnt;
  logic [7:0]      tenure_cnt;
  logic            as_ok;
  logic            bg_q;
  logic            as_q;

  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] win_onehot;
  logic [7:0]      wait_nxt;
  logic [7:0]      tenure_nxt;

  assign busy       = (state != S_IDLE);
  assign wait_nxt   = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
  assign tenure_nxt = (tenure_cnt == 8'hFF) ? tenure_cnt : tenure_cnt + 8'd1;

  // Round-robin search: first set request starting just after the last winner.
  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    win_onehot         = '0;
    win_onehot[winner] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      winner     <= '0;
      last       <= LAST_RST;
      wait_cnt   <= '0;
      tenure_cnt <= '0;
      as_ok      <= 1'b0;
      bg_q       <= 1'b1;
      as_q       <= 1'b1;
      gnt        <= '0;
      br_n       <= 1'b1;
      bgack_n    <= 1'b1;
      timeout    <= 1'b0;
    end else if (phi2) begin
      bg_q    <= bg_n;
      as_q    <= as_n;
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            winner   <= pick_idx;
            br_n     <= 1'b0;
            wait_cnt <= '0;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          wait_cnt <= wait_nxt;
          if (!bg_q) begin
            as_ok <= 1'b0;
            state <= S_WAITAS;
          end else if (wait_nxt >= TIMEOUT_LIM) begin
            br_n    <= 1'b1;
            timeout <= 1'b1;
            state   <= S_IDLE;
          end
        end
        S_WAITAS: begin
          // Two consecutive idle-strobe samples mean the CPU's bus cycle has ended.
          if (as_q) begin
            if (as_ok) begin
              gnt        <= win_onehot;
              bgack_n    <= 1'b0;
              br_n       <= 1'b1;
              last       <= winner;
              tenure_cnt <= '0;
              state      <= S_OWN;
            end else begin
              as_ok <= 1'b1;
            end
          end else begin
            as_ok <= 1'b0;
          end
        end
        S_OWN: begin
          tenure_cnt <= tenure_nxt;
          if (!req[winner] || (TENURE_LIMITED && tenure_cnt == TENURE_LAST)) begin
            gnt   <= '0;
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          bgack_n <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_st_bus_arbiter.sv
// Bench for st_bus_arbiter: directed handshake timing checks, then randomized episodes
// scored against a tenure-level round-robin model through a grant scoreboard.
module tb_st_bus_arbiter;

  localparam int NREQ  = 2;
  localparam int MAX_T = 4;
  localparam int BG_TO = 10;

  logic            clk     = 1'b0;
  logic            reset_n = 1'b0;
  logic            phi2    = 1'b0;
  logic            bg_n    = 1'b1;
  logic            as_n    = 1'b1;
  logic [NREQ-1:0] req     = '0;
  logic [NREQ-1:0] gnt;
  logic            br_n;
  logic            bgack_n;
  logic            busy;
  logic            timeout;

  st_bus_arbiter #(.NREQ(NREQ), .MAX_TENURE(MAX_T), .BG_TIMEOUT(BG_TO)) dut (
    .clk(clk), .reset_n(reset_n), .phi2(phi2), .req(req), .gnt(gnt), .br_n(br_n),
    .bg_n(bg_n), .bgack_n(bgack_n), .as_n(as_n), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int idx;
    int len;
  } grant_t;

  grant_t sb_q[$];
  bit     sb_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    phi2 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_clk();
    phi2 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    req = '0;
    for (int i = 0; i < 40 && busy; i++) tick();
    check(name, busy, 1'b0);
  endtask

  // Monitor: measures each grant pulse in phi2 ticks and scores it against the queue.
  initial begin : monitor
    int     cur_idx;
    int     cur_len;
    bit     ph;
    grant_t e;
    cur_idx = -1;
    cur_len = 0;
    forever begin
      @(posedge clk);
      ph = phi2;
      #1;
      if (!sb_en) begin
        cur_idx = -1;
        cur_len = 0;
      end else if (ph) begin
        check("inv_onehot", ($countones(gnt) <= 1), 1'b1);
        check("inv_no_timeout", timeout, 1'b0);
        check("inv_br_bgack_overlap", (!br_n && !bgack_n), 1'b0);
        if (gnt != '0) begin
          if (cur_idx < 0) begin
            cur_idx = idx_of(gnt);
            cur_len = 0;
          end
          cur_len++;
        end else if (cur_idx >= 0) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: grant idx %0d len %0d, expected no grant", cur_idx, cur_len);
          end else begin
            e = sb_q.pop_front();
            check("sb_idx", cur_idx, e.idx);
            check("sb_len", cur_len, e.len);
          end
          cur_idx = -1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int              rr_exp[3];
    int              np, cur, len;
    bit              gap_br, gap_ack;
    int              need[NREQ];
    int              rem[NREQ];
    int              model_last, c, found, total, glen, bg_dly;
    logic [NREQ-1:0] mask;
    bit              ph, done;
    grant_t          g;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 2'b00);
    check("rst_br_n", br_n, 1'b1);
    check("rst_bgack_n", bgack_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    #3 reset_n = 1'b1;
    repeat (2) tick();

    // Single request, BG answered two ticks after BR
    req = 2'b01;
    tick();
    check("single_br_n", br_n, 1'b0);
    check("single_busy", busy, 1'b1);
    tick();
    bg_n = 1'b0;
    tick();
    tick();
    check("single_gnt_t4", gnt, 2'b00);
    tick();
    check("single_gnt_t5", gnt, 2'b00);
    tick();
    check("single_gnt_t6", gnt, 2'b01);
    check("single_bgack_t6", bgack_n, 1'b0);
    check("single_br_t6", br_n, 1'b1);
    tick();
    check("single_hold", gnt, 2'b01);
    req = 2'b00;
    tick();
    check("single_gnt_fall", gnt, 2'b00);
    check("single_bgack_still", bgack_n, 1'b0);
    tick();
    check("single_bgack_rise", bgack_n, 1'b1);
    check("single_busy_end", busy, 1'b0);

    // AS gating: strobe low for several ticks while BG is already granted
    as_n = 1'b0;
    req  = 2'b01;
    tick();
    tick();
    for (int i = 3; i <= 9; i++) begin
      tick();
      check("as_hold", {gnt, bgack_n}, 3'b001);
      if (i == 7) as_n = 1'b1;
    end
    tick();
    check("as_grant", gnt, 2'b01);
    drain("as_drain");

    // BG timeout
    bg_n = 1'b1;
    tick();
    req = 2'b01;
    tick();
    check("to_br_low", br_n, 1'b0);
    for (int i = 2; i <= 10; i++) begin
      tick();
      check("to_wait", {br_n, timeout, busy, gnt}, 5'b00100);
    end
    tick();
    check("to_fire", {br_n, timeout, busy, gnt}, 5'b11000);
    req = 2'b00;
    tick();
    check("to_pulse_end", {br_n, timeout, busy}, 3'b100);

    // Reset mid-tenure, then minimum latency for index 1
    bg_n = 1'b0;
    tick();
    req = 2'b01;
    repeat (3) tick();
    check("lat_pre", gnt, 2'b00);
    tick();
    check("lat_4th", gnt, 2'b01);
    tick();
    #3 reset_n = 1'b0;
    #1;
    check("arst_gnt", gnt, 2'b00);
    check("arst_bgack", bgack_n, 1'b1);
    check("arst_br", br_n, 1'b1);
    check("arst_busy", busy, 1'b0);
    #2 reset_n = 1'b1;
    req = 2'b10;
    repeat (3) tick();
    check("arst_regrant_pre", gnt, 2'b00);
    tick();
    check("arst_regrant", gnt, 2'b10);
    drain("arst_drain");

    // Round-robin with both requests held
    rr_exp = '{0, 1, 0};
    np = 0; cur = -1; len = 0; gap_br = 1'b0; gap_ack = 1'b0;
    req = 2'b11;
    for (int i = 0; i < 100 && np < 3; i++) begin
      tick();
      if (gnt != '0) begin
        if (cur < 0) begin
          cur = idx_of(gnt);
          len = 0;
          if (np > 0) check("rr_gap", {gap_br, gap_ack}, 2'b11);
        end
        len++;
      end else begin
        if (cur >= 0) begin
          check("rr_idx", cur, rr_exp[np]);
          check("rr_len", len, MAX_T);
          np++;
          cur = -1; gap_br = 1'b0; gap_ack = 1'b0;
          if (np == 3) req = 2'b00;
        end
        if (!br_n) gap_br = 1'b1;
        if (bgack_n) gap_ack = 1'b1;
      end
    end
    check("rr_pulses", np, 3);
    drain("rr_drain");

    // phi2 gating: latency counted in phi2 ticks only
    req = 2'b01;
    repeat (20) idle_clk();
    check("phi2_frozen", {busy, br_n, gnt}, 4'b0100);
    tick(); idle_clk(); idle_clk();
    tick(); idle_clk();
    tick(); repeat (5) idle_clk();
    check("phi2_pre", {busy, gnt}, 3'b100);
    tick();
    check("phi2_grant", gnt, 2'b01);
    drain("phi2_drain");

    // Randomized episodes against a tenure-level model
    #3 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    model_last = NREQ - 1;
    bg_n = 1'b1;
    as_n = 1'b1;
    sb_en = 1'b1;
    for (int ep = 0; ep < 40; ep++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      total = 0;
      for (int i = 0; i < NREQ; i++) begin
        need[i] = mask[i] ? int'($urandom_range(1, 10)) : 0;
        rem[i]  = need[i];
        total  += need[i];
      end
      while (total > 0) begin
        found = -1;
        for (int k = 1; k <= NREQ; k++) begin
          c = (model_last + k) % NREQ;
          if (found < 0 && rem[c] > 0) found = c;
        end
        glen = (MAX_T == 0 || rem[found] < MAX_T) ? rem[found] : MAX_T;
        g.idx = found;
        g.len = glen;
        sb_q.push_back(g);
        rem[found] -= glen;
        total      -= glen;
        model_last  = found;
      end
      bg_dly = $urandom_range(0, 4);
      req  = mask;
      done = 1'b0;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
        ph = ($urandom_range(0, 3) != 0);
        phi2 = ph;
        @(posedge clk);
        #1;
        if (ph) begin
          for (int i = 0; i < NREQ; i++) begin
            if (need[i] > 0 && gnt[i]) begin
              need[i]--;
              if (need[i] == 0) req[i] = 1'b0;
            end
          end
          if (!br_n) begin
            if (bg_n) begin
              if (bg_dly == 0) bg_n = 1'b0;
              else bg_dly--;
            end
          end else if (bgack_n) begin
            bg_n   = 1'b1;
            bg_dly = $urandom_range(0, 4);
          end
          as_n = !bgack_n ? 1'b1 : ($urandom_range(0, 3) != 0);
          if (req == '0 && !busy) done = 1'b1;
        end
      end
      check("ep_idle", busy, 1'b0);
      check("ep_sb_empty", sb_q.size(), 0);
    end
    sb_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
